// File: rtl/cpu_pkg.sv
// Shared opcode, state and control-strobe definitions for the 8-bit CPU sequencer.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 3;

  // Micro-step states; the encoding is visible on the debug state port.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC0  = 3'd4,
    ST_EXEC1  = 3'd5,
    ST_EXEC2  = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  // One bit per datapath enable strobe driven by the sequencer.
  typedef struct packed {
    logic pc_out_en;
    logic pc_in_en;
    logic pc_inc;
    logic mar_in_en;
    logic mem_rd;
    logic mem_wr;
    logic ir_in_en;
    logic ir_out_en;
    logic a_in_en;
    logic a_out_en;
    logic b_in_en;
    logic alu_out_en;
    logic alu_sub;
    logic out_in_en;
  } ctrl_t;

  // Opcodes whose EXEC1 step performs a memory access and may stall.
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    logic r;
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_control_sequencer.sv
// Micro-step sequencer: fetch / decode / execute strobes with a ready-stalled memory handshake.
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  input  logic                mem_ready,
  output logic                pc_out_en,
  output logic                pc_in_en,
  output logic                pc_inc,
  output logic                mar_in_en,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                ir_in_en,
  output logic                ir_out_en,
  output logic                a_in_en,
  output logic                a_out_en,
  output logic                b_in_en,
  output logic                alu_out_en,
  output logic                alu_sub,
  output logic                out_in_en,
  output logic [STATE_W-1:0]  state,
  output logic                halted,
  output logic                bus_err
);

  localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                mem_step_c;
  logic                timeout_c;
  ctrl_t               ctrl_c;

  // A memory step is FETCH2, or EXEC1 of an opcode that touches RAM.
  always_comb begin
    mem_step_c = (state_q == ST_FETCH2) ||
                 ((state_q == ST_EXEC1) && is_mem_op(opcode_q));
    timeout_c  = (WAIT_LIMIT != 0) && mem_step_c && !mem_ready &&
                 (32'(wait_cnt_q) == WAIT_LIMIT);
  end

  // State, latched opcode, stall counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH0;
      opcode_q   <= '0;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state, opcode latch, stall counting and timeout handling.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    bus_err_d  = bus_err_q;
    wait_cnt_d = '0;

    // Counter only advances while a request is pending without ready.
    if ((WAIT_LIMIT != 0) && mem_step_c && !mem_ready && !timeout_c) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_FETCH0: begin
        if (run) state_d = ST_FETCH1;
      end
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: begin
        if (timeout_c) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else if (mem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opcode_d = ir_opcode;
        state_d  = (ir_opcode == OP_HLT) ? ST_HALT : ST_EXEC0;
      end
      ST_EXEC0: begin
        state_d = is_mem_op(opcode_q) ? ST_EXEC1 : ST_FETCH0;
      end
      ST_EXEC1: begin
        if (!is_mem_op(opcode_q)) begin
          state_d = ST_FETCH0;
        end else if (timeout_c) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else if (mem_ready) begin
          state_d = ((opcode_q == OP_ADD) || (opcode_q == OP_SUB)) ? ST_EXEC2 : ST_FETCH0;
        end
      end
      ST_EXEC2: state_d = ST_FETCH0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH0;
    endcase
  end

  // Strobe decode from state, latched opcode, flags and ready; forced low while in reset.
  always_comb begin
    ctrl_c = '0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH0: ctrl_c.pc_out_en = run;
        ST_FETCH1: begin
          ctrl_c.mar_in_en = 1'b1;
          ctrl_c.pc_inc    = 1'b1;
        end
        ST_FETCH2: begin
          if (!timeout_c) begin
            ctrl_c.mem_rd   = 1'b1;
            ctrl_c.ir_in_en = mem_ready;
          end
        end
        ST_EXEC0: begin
          case (opcode_q)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl_c.ir_out_en = 1'b1;
              ctrl_c.mar_in_en = 1'b1;
            end
            OP_LDI: begin
              ctrl_c.ir_out_en = 1'b1;
              ctrl_c.a_in_en   = 1'b1;
            end
            OP_JMP: begin
              ctrl_c.ir_out_en = 1'b1;
              ctrl_c.pc_in_en  = 1'b1;
            end
            OP_JC: begin
              ctrl_c.ir_out_en = flag_c;
              ctrl_c.pc_in_en  = flag_c;
            end
            OP_JZ: begin
              ctrl_c.ir_out_en = flag_z;
              ctrl_c.pc_in_en  = flag_z;
            end
            OP_OUT: begin
              ctrl_c.a_out_en  = 1'b1;
              ctrl_c.out_in_en = 1'b1;
            end
            default: ctrl_c = '0;
          endcase
        end
        ST_EXEC1: begin
          if (!timeout_c) begin
            case (opcode_q)
              OP_LDA: begin
                ctrl_c.mem_rd  = 1'b1;
                ctrl_c.a_in_en = mem_ready;
              end
              OP_ADD, OP_SUB: begin
                ctrl_c.mem_rd  = 1'b1;
                ctrl_c.b_in_en = mem_ready;
              end
              OP_STA: begin
                ctrl_c.a_out_en = 1'b1;
                ctrl_c.mem_wr   = 1'b1;
              end
              default: ctrl_c = '0;
            endcase
          end
        end
        ST_EXEC2: begin
          if ((opcode_q == OP_ADD) || (opcode_q == OP_SUB)) begin
            ctrl_c.alu_out_en = 1'b1;
            ctrl_c.a_in_en    = 1'b1;
            ctrl_c.alu_sub    = (opcode_q == OP_SUB);
          end
        end
        default: ctrl_c = '0;
      endcase
    end
  end

  assign pc_out_en  = ctrl_c.pc_out_en;
  assign pc_in_en   = ctrl_c.pc_in_en;
  assign pc_inc     = ctrl_c.pc_inc;
  assign mar_in_en  = ctrl_c.mar_in_en;
  assign mem_rd     = ctrl_c.mem_rd;
  assign mem_wr     = ctrl_c.mem_wr;
  assign ir_in_en   = ctrl_c.ir_in_en;
  assign ir_out_en  = ctrl_c.ir_out_en;
  assign a_in_en    = ctrl_c.a_in_en;
  assign a_out_en   = ctrl_c.a_out_en;
  assign b_in_en    = ctrl_c.b_in_en;
  assign alu_out_en = ctrl_c.alu_out_en;
  assign alu_sub    = ctrl_c.alu_sub;
  assign out_in_en  = ctrl_c.out_in_en;
  assign state      = state_q;
  assign halted     = (state_q == ST_HALT);
  assign bus_err    = bus_err_q;

endmodule
